switch_debounce: RTL and testbench



---
 rtl/switch_debounce.sv | 129 ++++++++++++
 tb/tb_switch_debounce.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchroniser, per-byte debounce and glitch-free
// registered outputs for four 8-bit DIP-switch banks.
// Optional macro SWITCH_DB_IRQ_EN: when defined, per-bank sticky change flags
// with ack/clear and a level interrupt are built; otherwise chg_flags and irq
// are tied low and irq_ack/chg_clr are ignored.
//
// Timing: a raw change ahead of edge E is accepted into the stable value at
// edge E+2+DEBOUNCE_CYCLES. The registered *_db outputs and the change flags
// follow one edge later, so both become visible after edge E+3+DEBOUNCE_CYCLES.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] user0_dipsw,
  input  logic [7:0] user1_dipsw,
  input  logic [7:0] user2_dipsw,
  input  logic [7:0] user3_dipsw,
  output logic [7:0] user0_dipsw_db,
  output logic [7:0] user1_dipsw_db,
  output logic [7:0] user2_dipsw_db,
  output logic [7:0] user3_dipsw_db,
  input  logic [3:0] chg_clr,
  input  logic       irq_ack,
  output logic [3:0] chg_flags,
  output logic       irq
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       w_raw        [4];
  logic [7:0]       r_sync1      [4];
  logic [7:0]       r_sync2      [4];
  logic [7:0]       r_cand       [4];
  logic [7:0]       r_stable     [4];
  logic [7:0]       r_db         [4];
  logic [CNT_W-1:0] r_cnt        [4];
  logic [CNT_W-1:0] w_cnt_nxt    [4];
  logic [7:0]       w_stable_nxt [4];
  logic [3:0]       w_acc;

  assign w_raw[0] = user0_dipsw;
  assign w_raw[1] = user1_dipsw;
  assign w_raw[2] = user2_dipsw;
  assign w_raw[3] = user3_dipsw;

  assign user0_dipsw_db = r_db[0];
  assign user1_dipsw_db = r_db[1];
  assign user2_dipsw_db = r_db[2];
  assign user3_dipsw_db = r_db[3];

  // Debounce decision per bank: hold, restart on movement, count, or accept.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_cnt_nxt[i]    = '0;
      w_stable_nxt[i] = r_stable[i];
      w_acc[i]        = 1'b0;
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_sync2[i] != r_cand[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == TC) begin
        w_stable_nxt[i] = r_sync2[i];
        w_acc[i]        = 1'b1;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  // Synchroniser, candidate, counter, stable value and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_sync1[i]  <= '0;
        r_sync2[i]  <= '0;
        r_cand[i]   <= '0;
        r_stable[i] <= '0;
        r_db[i]     <= '0;
        r_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_sync1[i]  <= w_raw[i];
        r_sync2[i]  <= r_sync1[i];
        r_cand[i]   <= r_sync2[i];
        r_stable[i] <= w_stable_nxt[i];
        r_db[i]     <= r_stable[i];
        r_cnt[i]    <= w_cnt_nxt[i];
      end
    end
  end

`ifdef SWITCH_DB_IRQ_EN
  logic [3:0] r_acc;
  logic [3:0] r_chg;

  // Delay the accept pulse so flags line up with the registered *_db update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc;
    end
  end

  // Sticky change flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chg <= '0;
    end else if (irq_ack) begin
      r_chg <= (r_chg & ~chg_clr) | r_acc;
    end else begin
      r_chg <= r_chg | r_acc;
    end
  end

  assign chg_flags = r_chg;
  assign irq       = |r_chg;
`else
  logic w_unused;

  assign w_unused  = ^{irq_ack, chg_clr, w_acc};
  assign chg_flags = 4'b0000;
  assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
// A raw change made between edges is expected on *_db after the 8th edge
// that follows it (edge E+7 when the first edge is E).
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] u0, u1, u2, u3;
  logic [7:0] db0, db1, db2, db3;
  logic [3:0] chg_clr;
  logic       irq_ack;
  logic [3:0] chg_flags;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;

  switch_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .user0_dipsw    (u0),
    .user1_dipsw    (u1),
    .user2_dipsw    (u2),
    .user3_dipsw    (u3),
    .user0_dipsw_db (db0),
    .user1_dipsw_db (db1),
    .user2_dipsw_db (db2),
    .user3_dipsw_db (db3),
    .chg_clr        (chg_clr),
    .irq_ack        (irq_ack),
    .chg_flags      (chg_flags),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] fx(input logic [3:0] f);
`ifdef SWITCH_DB_IRQ_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic chk_flags(input string tag, input logic [3:0] f);
    chk({tag, "_flags"}, {28'd0, chg_flags}, {28'd0, fx(f)});
    chk({tag, "_irq"}, {31'd0, irq}, {31'd0, (fx(f) != 4'b0000)});
  endtask

  task automatic ack(input logic [3:0] clr);
    chg_clr = clr;
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chg_clr = 4'b0000;
  endtask

  initial begin
    rst_n   = 1'b1;
    u0      = 8'hA5;
    u1      = 8'h00;
    u2      = 8'h00;
    u3      = 8'h00;
    chg_clr = 4'b0000;
    irq_ack = 1'b0;

    // Reset takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_db0", {24'd0, db0}, 32'h00);
    chk("rst_db1", {24'd0, db1}, 32'h00);
    chk("rst_db2", {24'd0, db2}, 32'h00);
    chk("rst_db3", {24'd0, db3}, 32'h00);
    chk_flags("rst", 4'b0000);
    tick(2);
    chk("rst_hold_db0", {24'd0, db0}, 32'h00);
    rst_n = 1'b1;

    // 1: steady A5 from release; visible after edge 7 only
    tick(7);
    chk("t1_early_db0", {24'd0, db0}, 32'h00);
    chk_flags("t1_early", 4'b0000);
    tick(1);
    chk("t1_db0", {24'd0, db0}, 32'hA5);
    chk_flags("t1", 4'b0001);
    chk("t1_db1", {24'd0, db1}, 32'h00);
    chk("t1_db2", {24'd0, db2}, 32'h00);
    chk("t1_db3", {24'd0, db3}, 32'h00);

    // 2: 3-cycle glitch on bank 2 is rejected
    u2 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("t2_glitch_db2", {24'd0, db2}, 32'h00);
    end
    u2 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("t2_after_db2", {24'd0, db2}, 32'h00);
    end
    chk_flags("t2", 4'b0001);

    // Bring bank 2 to a new value to get flags 0101
    u2 = 8'h5A;
    tick(8);
    chk("t4_db2", {24'd0, db2}, 32'h5A);
    chk_flags("t4_set", 4'b0101);

    // 4: ack/clear
    ack(4'b0000);
    chk_flags("t4_noclr", 4'b0101);
    ack(4'b0001);
    chk_flags("t4_clr0", 4'b0100);
    ack(4'b0100);
    chk_flags("t4_clr2", 4'b0000);

    // 3: bank 1 bounces every 2 cycles, then holds 0F
    for (int s = 0; s < 10; s++) begin
      u1 = (s % 2 == 0) ? 8'h0F : 8'h00;
      for (int k = 0; k < 2; k++) begin
        tick(1);
        chk("t3_bounce_db1", {24'd0, db1}, 32'h00);
      end
    end
    u1 = 8'h0F;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      chk("t3_wait_db1", {24'd0, db1}, 32'h00);
    end
    tick(1);
    chk("t3_db1", {24'd0, db1}, 32'h0F);
    chk_flags("t3", 4'b0010);

    // 5: clear of bank 3 on the edge its flag is set; set wins
    u3 = 8'hC3;
    tick(7);
    chk("t5_early_db3", {24'd0, db3}, 32'h00);
    ack(4'b1000);
    chk("t5_db3", {24'd0, db3}, 32'hC3);
    chk("t5_flag3", {31'd0, chg_flags[3]}, {31'd0, fx(4'b1000) != 4'b0000});
    chk_flags("t5", 4'b1010);

    // 6: reset while bank 0 counter is at 2
    u0 = 8'h3C;
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_db0", {24'd0, db0}, 32'h00);
    chk("t6_rst_db1", {24'd0, db1}, 32'h00);
    chk("t6_rst_db2", {24'd0, db2}, 32'h00);
    chk("t6_rst_db3", {24'd0, db3}, 32'h00);
    chk_flags("t6_rst", 4'b0000);
    tick(1);
    rst_n = 1'b1;
    tick(7);
    chk("t6_early_db0", {24'd0, db0}, 32'h00);
    chk("t6_early_db3", {24'd0, db3}, 32'h00);
    tick(1);
    chk("t6_db0", {24'd0, db0}, 32'h3C);
    chk("t6_db1", {24'd0, db1}, 32'h0F);
    chk("t6_db2", {24'd0, db2}, 32'h5A);
    chk("t6_db3", {24'd0, db3}, 32'hC3);
    chk_flags("t6", 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
